// File: rtl/cache_controller.sv
// ---------------------------------------------------------------------------
// cache_controller
//
// Request-side controller for an N-way set-associative, write-back /
// write-allocate cache data array. One CPU word request is serviced at a
// time. The request is latched on acceptance. The address is split into
// tag/index/offset for the array, and the controller sequences the array
// strobes for lookup, dirty-victim writeback, refill and retry. A simple
// request/acknowledge handshake goes to main memory through a registered
// writeback buffer and a registered refill buffer.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cpu_req_*           CPU request (valid/ready, type, address, write data)
//   cpu_resp_valid      one-cycle completion pulse
//   cpu_rdata           read data, qualified by cpu_resp_valid
//   c_tag/c_index/
//   c_blk_offset,
//   c_req_type,
//   c_data_in           latched request fields driven to the data array
//   c_data_in_mem       refill buffer driven to the data array
//   c_*_en_*            data array strobes
//   c_hit, c_dirty,
//   c_data_out,
//   c_dirty_block_out,
//   c_victim_tag        data array status and read data
//   mem_*               main memory request/acknowledge interface
// ---------------------------------------------------------------------------
module cache_controller #(
  parameter int WORD_SIZE       = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int BLOCK_SIZE      = WORDS_PER_BLOCK * WORD_SIZE,
  parameter int NUM_BLOCKS      = 64,
  parameter int NUM_WAYS        = 4,
  parameter int NUM_SETS        = NUM_BLOCKS / NUM_WAYS,
  parameter int INDEX_WIDTH     = $clog2(NUM_SETS),
  parameter int OFFSET_WIDTH    = $clog2(WORDS_PER_BLOCK),
  parameter int TAG_WIDTH       = 32 - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  // CPU side
  input  logic                    cpu_req_valid,
  output logic                    cpu_req_ready,
  input  logic                    cpu_req_type,
  input  logic [31:0]             cpu_addr,
  input  logic [WORD_SIZE-1:0]    cpu_wdata,
  output logic                    cpu_resp_valid,
  output logic [WORD_SIZE-1:0]    cpu_rdata,
  // Data array side
  output logic [TAG_WIDTH-1:0]    c_tag,
  output logic [INDEX_WIDTH-1:0]  c_index,
  output logic [OFFSET_WIDTH-1:0] c_blk_offset,
  output logic                    c_req_type,
  output logic [WORD_SIZE-1:0]    c_data_in,
  output logic [BLOCK_SIZE-1:0]   c_data_in_mem,
  output logic                    c_read_en_cache,
  output logic                    c_write_en_cache,
  output logic                    c_read_en_mem,
  output logic                    c_write_en_mem,
  input  logic                    c_hit,
  input  logic                    c_dirty,
  input  logic [WORD_SIZE-1:0]    c_data_out,
  input  logic [BLOCK_SIZE-1:0]   c_dirty_block_out,
  input  logic [TAG_WIDTH-1:0]    c_victim_tag,
  // Main memory side
  output logic                    mem_rd_req,
  output logic                    mem_wr_req,
  output logic [31:0]             mem_addr,
  output logic [BLOCK_SIZE-1:0]   mem_wdata,
  input  logic                    mem_ack,
  input  logic [BLOCK_SIZE-1:0]   mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    RESP,
    WB_ISSUE,
    WB_CAPTURE,
    WB_WAIT,
    ALLOC_WAIT,
    REFILL
  } state_t;

  state_t                  state_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [TAG_WIDTH-1:0]    victim_tag_q;
  logic [INDEX_WIDTH-1:0]  index_q;
  logic [OFFSET_WIDTH-1:0] offset_q;
  logic                    req_type_q;
  logic [WORD_SIZE-1:0]    wdata_q;
  logic [BLOCK_SIZE-1:0]   wb_buf_q;
  logic [BLOCK_SIZE-1:0]   refill_buf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      victim_tag_q <= '0;
      index_q      <= '0;
      offset_q     <= '0;
      req_type_q   <= 1'b0;
      wdata_q      <= '0;
      wb_buf_q     <= '0;
      refill_buf_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req_valid) begin
            tag_q      <= cpu_addr[OFFSET_WIDTH+INDEX_WIDTH +: TAG_WIDTH];
            index_q    <= cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
            offset_q   <= cpu_addr[0 +: OFFSET_WIDTH];
            req_type_q <= cpu_req_type;
            wdata_q    <= cpu_wdata;
            state_q    <= COMPARE;
          end
        end
        COMPARE: begin
          if (c_hit) begin
            state_q <= RESP;
          end else if (c_dirty) begin
            // The victim tag is only valid while the index is presented in
            // this cycle, so it is held for the writeback address.
            victim_tag_q <= c_victim_tag;
            state_q      <= WB_ISSUE;
          end else begin
            state_q <= ALLOC_WAIT;
          end
        end
        RESP:       state_q <= IDLE;
        WB_ISSUE:   state_q <= WB_CAPTURE;
        WB_CAPTURE: begin
          // The array registers the dirty block one cycle after WB_ISSUE.
          wb_buf_q <= c_dirty_block_out;
          state_q  <= WB_WAIT;
        end
        WB_WAIT: begin
          if (mem_ack) state_q <= ALLOC_WAIT;
        end
        ALLOC_WAIT: begin
          if (mem_ack) begin
            refill_buf_q <= mem_rdata;
            state_q      <= REFILL;
          end
        end
        // After a refill the access is retried; a repeated miss simply
        // re-enters the miss path.
        REFILL:  state_q <= COMPARE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // All outputs below depend only on registered state and array responses.
  assign cpu_req_ready  = (state_q == IDLE);
  assign cpu_resp_valid = (state_q == RESP);
  assign cpu_rdata      = (state_q == RESP && !req_type_q) ? c_data_out : '0;

  assign c_tag          = tag_q;
  assign c_index        = index_q;
  assign c_blk_offset   = offset_q;
  assign c_req_type     = req_type_q;
  assign c_data_in      = wdata_q;
  assign c_data_in_mem  = refill_buf_q;

  assign c_read_en_cache  = (state_q == COMPARE && c_hit && !req_type_q)
                            || (state_q == WB_ISSUE);
  assign c_write_en_cache = (state_q == COMPARE && c_hit && req_type_q)
                            || (state_q == REFILL);
  assign c_read_en_mem    = (state_q == REFILL);
  assign c_write_en_mem   = (state_q == WB_ISSUE);

  assign mem_rd_req = (state_q == ALLOC_WAIT);
  assign mem_wr_req = (state_q == WB_WAIT);
  assign mem_addr   = (state_q == WB_WAIT)
                      ? {victim_tag_q, index_q, {OFFSET_WIDTH{1'b0}}}
                      : {tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
  assign mem_wdata  = wb_buf_q;

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

  localparam int WS  = 32;
  localparam int BS  = 128;
  localparam int TW  = 26;
  localparam int IW  = 4;
  localparam int OW  = 2;

  localparam logic [BS-1:0] RBLK1 = 128'h00000004_00000003_00001234_00000001;
  localparam logic [BS-1:0] WBBLK = 128'hA5A5A5A5_11112222_33334444_55556666;
  localparam logic [BS-1:0] RBLK2 = 128'h0BAD0BAD_77778888_9999AAAA_BBBBCCCC;

  logic          clk;
  logic          rst;
  logic          cpu_req_valid;
  logic          cpu_req_ready;
  logic          cpu_req_type;
  logic [31:0]   cpu_addr;
  logic [WS-1:0] cpu_wdata;
  logic          cpu_resp_valid;
  logic [WS-1:0] cpu_rdata;
  logic [TW-1:0] c_tag;
  logic [IW-1:0] c_index;
  logic [OW-1:0] c_blk_offset;
  logic          c_req_type;
  logic [WS-1:0] c_data_in;
  logic [BS-1:0] c_data_in_mem;
  logic          c_read_en_cache;
  logic          c_write_en_cache;
  logic          c_read_en_mem;
  logic          c_write_en_mem;
  logic          c_hit;
  logic          c_dirty;
  logic [WS-1:0] c_data_out;
  logic [BS-1:0] c_dirty_block_out;
  logic [TW-1:0] c_victim_tag;
  logic          mem_rd_req;
  logic          mem_wr_req;
  logic [31:0]   mem_addr;
  logic [BS-1:0] mem_wdata;
  logic          mem_ack;
  logic [BS-1:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  cache_controller dut (
    .clk              (clk),
    .rst              (rst),
    .cpu_req_valid    (cpu_req_valid),
    .cpu_req_ready    (cpu_req_ready),
    .cpu_req_type     (cpu_req_type),
    .cpu_addr         (cpu_addr),
    .cpu_wdata        (cpu_wdata),
    .cpu_resp_valid   (cpu_resp_valid),
    .cpu_rdata        (cpu_rdata),
    .c_tag            (c_tag),
    .c_index          (c_index),
    .c_blk_offset     (c_blk_offset),
    .c_req_type       (c_req_type),
    .c_data_in        (c_data_in),
    .c_data_in_mem    (c_data_in_mem),
    .c_read_en_cache  (c_read_en_cache),
    .c_write_en_cache (c_write_en_cache),
    .c_read_en_mem    (c_read_en_mem),
    .c_write_en_mem   (c_write_en_mem),
    .c_hit            (c_hit),
    .c_dirty          (c_dirty),
    .c_data_out       (c_data_out),
    .c_dirty_block_out(c_dirty_block_out),
    .c_victim_tag     (c_victim_tag),
    .mem_rd_req       (mem_rd_req),
    .mem_wr_req       (mem_wr_req),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BS-1:0] obs, input logic [BS-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bundles the strobe/request outputs for compact "nothing active" checks.
  function automatic logic [5:0] acts();
    return {c_read_en_cache, c_write_en_cache, c_read_en_mem,
            c_write_en_mem, mem_rd_req, mem_wr_req};
  endfunction

  initial begin
    rst = 1'b1;
    cpu_req_valid = 1'b0; cpu_req_type = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    c_hit = 1'b0; c_dirty = 1'b0; c_data_out = '0; c_dirty_block_out = '0;
    c_victim_tag = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;

    // ---------------- reset state ----------------
    chk("rst_ready", 128'(cpu_req_ready), 128'(1'b1));
    chk("rst_resp", 128'(cpu_resp_valid), 128'(1'b0));
    chk("rst_acts", 128'(acts()), 128'(6'b0));
    chk("rst_rdata", 128'(cpu_rdata), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_bufs", {c_data_in_mem}, 128'(0));
    $display("txn reset done");

    // ---------------- read hit at 0x40 ----------------
    cpu_req_valid = 1'b1; cpu_req_type = 1'b0; cpu_addr = 32'h40;
    tick();                                     // cycle 1: COMPARE
    cpu_req_valid = 1'b0; c_hit = 1'b1;
    #1;
    chk("hit_rd_en", 128'(c_read_en_cache), 128'(1'b1));
    chk("hit_wr_en", 128'(c_write_en_cache), 128'(1'b0));
    chk("hit_tag", 128'(c_tag), 128'(1));
    chk("hit_index", 128'(c_index), 128'(0));
    chk("hit_ready", 128'(cpu_req_ready), 128'(1'b0));
    tick();                                     // cycle 2: RESP
    c_hit = 1'b0; c_data_out = 32'hDEADBEEF;
    #1;
    chk("hit_resp", 128'(cpu_resp_valid), 128'(1'b1));
    chk("hit_rdata", 128'(cpu_rdata), 128'(32'hDEADBEEF));
    chk("hit_no_mem", 128'({mem_rd_req, mem_wr_req}), 128'(2'b0));
    tick();
    chk("hit_idle", 128'({cpu_req_ready, cpu_resp_valid}), 128'(2'b10));
    $display("txn read hit addr=0x40 done");

    // ---------------- clean read miss, L=3, addr 0x8D ----------------
    cpu_req_valid = 1'b1; cpu_req_type = 1'b0; cpu_addr = 32'h8D;
    tick();                                     // cycle 1: COMPARE
    cpu_req_valid = 1'b0; c_hit = 1'b0; c_dirty = 1'b0;
    #1;
    chk("cm_cmp_acts", 128'(acts()), 128'(6'b0));
    tick();                                     // cycle 2: ALLOC_WAIT
    chk("cm_rd_req", 128'({mem_rd_req, mem_wr_req}), 128'(2'b10));
    chk("cm_addr", 128'(mem_addr), 128'(32'h8C));
    cpu_addr = 32'hFFFF_FFF0;                   // must be ignored
    tick();                                     // cycle 3
    chk("cm_addr_hold", 128'(mem_addr), 128'(32'h8C));
    chk("cm_index_hold", 128'(c_index), 128'(3));
    tick();                                     // cycle 4: ack cycle
    chk("cm_rd_req_c4", 128'(mem_rd_req), 128'(1'b1));
    mem_ack = 1'b1; mem_rdata = RBLK1;
    tick();                                     // cycle 5: REFILL
    mem_ack = 1'b0; mem_rdata = '0;
    #1;
    chk("cm_refill_str", 128'(acts()), 128'(6'b011000));
    chk("cm_refill_blk", c_data_in_mem, RBLK1);
    tick();                                     // cycle 6: COMPARE retry
    c_hit = 1'b1;
    #1;
    chk("cm_retry_rd", 128'(acts()), 128'(6'b100000));
    tick();                                     // cycle 7: RESP
    c_hit = 1'b0; c_data_out = 32'h1234;
    #1;
    chk("cm_resp", 128'(cpu_resp_valid), 128'(1'b1));
    chk("cm_rdata", 128'(cpu_rdata), 128'(32'h1234));
    tick();
    $display("txn clean read miss addr=0x8D done");

    // ---------------- dirty write miss, victim tag 0x5 ----------------
    cpu_req_valid = 1'b1; cpu_req_type = 1'b1; cpu_addr = 32'h1CB;
    cpu_wdata = 32'hCAFEF00D;
    tick();                                     // COMPARE
    cpu_req_valid = 1'b0; cpu_wdata = 32'h0;
    c_hit = 1'b0; c_dirty = 1'b1; c_victim_tag = 26'h5;
    #1;
    chk("dm_cmp_wr", 128'(c_write_en_cache), 128'(1'b0));
    tick();                                     // WB_ISSUE
    c_dirty = 1'b0; c_victim_tag = 26'h3F; c_dirty_block_out = WBBLK;
    #1;
    chk("dm_wb_issue", 128'(acts()), 128'(6'b100100));
    tick();                                     // WB_CAPTURE
    chk("dm_wb_cap", 128'(acts()), 128'(6'b0));
    tick();                                     // WB_WAIT
    c_dirty_block_out = '0;
    chk("dm_wr_req", 128'({mem_rd_req, mem_wr_req}), 128'(2'b01));
    chk("dm_wb_addr", 128'(mem_addr), 128'(32'h148));
    chk("dm_wb_data", mem_wdata, WBBLK);
    mem_ack = 1'b1;
    tick();                                     // ALLOC_WAIT
    mem_ack = 1'b0;
    chk("dm_rd_req", 128'({mem_rd_req, mem_wr_req}), 128'(2'b10));
    chk("dm_alloc_addr", 128'(mem_addr), 128'(32'h1C8));
    mem_ack = 1'b1; mem_rdata = RBLK2;
    tick();                                     // REFILL
    mem_ack = 1'b0; mem_rdata = '0;
    chk("dm_refill_str", 128'(acts()), 128'(6'b011000));
    chk("dm_refill_blk", c_data_in_mem, RBLK2);
    tick();                                     // COMPARE retry
    c_hit = 1'b1;
    #1;
    chk("dm_final_wr", 128'(acts()), 128'(6'b010000));
    chk("dm_data_in", 128'(c_data_in), 128'(32'hCAFEF00D));
    chk("dm_fields", 128'({c_req_type, c_blk_offset, c_index}), 128'({1'b1, 2'd3, 4'd2}));
    tick();                                     // RESP
    c_hit = 1'b0; c_data_out = 32'h55AA55AA;
    #1;
    chk("dm_resp", 128'({cpu_resp_valid, cpu_rdata}), 128'({1'b1, 32'h0}));
    tick();
    $display("txn dirty write miss addr=0x1CB done");

    // ---------------- back-to-back hits, valid held ----------------
    cpu_req_valid = 1'b1; cpu_req_type = 1'b0; cpu_addr = 32'h40;
    tick();                                     // COMPARE (A)
    c_hit = 1'b1; cpu_addr = 32'h45;
    chk("b2b_busy", 128'(cpu_req_ready), 128'(1'b0));
    tick();                                     // RESP (A)
    chk("b2b_resp_a", 128'({cpu_resp_valid, cpu_req_ready}), 128'(2'b10));
    tick();                                     // IDLE, accepts B
    chk("b2b_idle", 128'({cpu_resp_valid, cpu_req_ready}), 128'(2'b01));
    tick();                                     // COMPARE (B)
    cpu_req_valid = 1'b0;
    chk("b2b_b_offset", 128'(c_blk_offset), 128'(1));
    chk("b2b_b_cmp", 128'({cpu_resp_valid, cpu_req_ready}), 128'(2'b00));
    tick();                                     // RESP (B)
    c_hit = 1'b0;
    chk("b2b_resp_b", 128'(cpu_resp_valid), 128'(1'b1));
    tick();
    chk("b2b_after", 128'({cpu_resp_valid, cpu_req_ready}), 128'(2'b01));
    tick();
    chk("b2b_quiet", 128'({cpu_resp_valid, cpu_req_ready}), 128'(2'b01));
    $display("txn back-to-back hits done");

    // ---------------- reset during ALLOC_WAIT ----------------
    cpu_req_valid = 1'b1; cpu_req_type = 1'b0; cpu_addr = 32'h8D;
    tick();                                     // COMPARE
    cpu_req_valid = 1'b0; c_hit = 1'b0; c_dirty = 1'b0;
    tick();                                     // ALLOC_WAIT
    chk("rs_rd_req", 128'(mem_rd_req), 128'(1'b1));
    rst = 1'b1;
    tick();                                     // reset applied
    rst = 1'b0;
    chk("rs_state", 128'({cpu_req_ready, cpu_resp_valid, mem_rd_req}), 128'(3'b100));
    chk("rs_index", 128'(c_index), 128'(0));
    mem_ack = 1'b1; mem_rdata = RBLK1;          // late ack
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    chk("rs_late_acts", 128'(acts()), 128'(6'b0));
    chk("rs_late_buf", c_data_in_mem, 128'(0));
    tick();
    chk("rs_quiet", 128'({cpu_req_ready, cpu_resp_valid, acts()}), 128'({2'b10, 6'b0}));
    $display("txn reset during alloc done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
